spi_master_arbiter: RTL and testbench
=====================================

# spi_master_arbiter

Clock-domain SPI master that drives the `SPI_slave` bus pins (`sclk`, `ss`, `mosi`, `miso`) and shares that single link between two on-chip requesters. The block arbitrates, frames one `WIDTH`-bit full-duplex transfer per grant, and returns the captured `miso` word to the owning requester. It sits between user logic and the board GPIO pins that the `SPI_slave` side listens on.

## Interface
- `WIDTH`, 8, bits per transfer; shifted MSB first.
- `CLK_DIV`, 4, `clk` cycles per `sclk` half-period; legal range ≥2.

- `clk` input 1 system clock; all state updates on its rising edge.
- `rst_L` input 1 reset; asynchronous, active-low.
- `req` input 2 per-requester transfer request, level.
- `tx_data_0` input WIDTH word for requester 0; sampled at its grant edge.
- `tx_data_1` input WIDTH word for requester 1; sampled at its grant edge.
- `gnt` output 2 one-hot, one-cycle pulse marking the accepted request.
- `rx_valid` output 2 one-hot, one-cycle pulse to the owner at transfer end.
- `rx_data` output WIDTH last captured `miso` word; holds until the next `rx_valid`.
- `busy` output 1 high from the grant edge through the DONE cycle.
- `sclk` output 1 SPI clock; idles low.
- `ss` output 1 slave select; active high.
- `mosi` output 1 serial data to the slave.
- `miso` input 1 serial data from the slave.

## Operation
- SPI mode 0:
  - `mosi` changes while `sclk` is low.
  - Both ends sample on the `sclk` rise.
- All outputs are registered.
- FSM states: IDLE, LEAD, HIGH, LOW, TRAIL, DONE.
- IDLE:
  - `ss`=0, `sclk`=0, `mosi`=0.
  - If any `req` bit is set, pick a winner, load the shift register from its `tx_data_*`, latch the owner, and pulse `gnt[owner]`.
  - Next state: LEAD.
- LEAD: `ss`=1; `mosi`=bit WIDTH-1; lasts CLK_DIV cycles; next state HIGH.
- HIGH:
  - On entry, `sclk` goes 1 and `miso` is shifted into the receive register LSB.
  - Lasts CLK_DIV cycles.
  - After the WIDTH-th HIGH, go to TRAIL; otherwise go to LOW.
- LOW:
  - On entry, `sclk` goes 0 and `mosi` advances to the next lower bit.
  - Lasts CLK_DIV cycles; next state HIGH.
- TRAIL: `sclk`=0, `ss`=1, `mosi` holds bit 0; lasts CLK_DIV cycles.
- DONE:
  - `ss`=0, `mosi`=0.
  - `rx_data` ← receive register; pulse `rx_valid[owner]`.
  - Next state: IDLE.
- Requester rules:
  - Hold `req` and `tx_data_*` stable until `gnt`.
  - Dropping `req` before `gnt` withdraws the request, with no side effects.
  - `req` still high after `gnt` is a new request.
- `req` is ignored outside IDLE; no queueing.
- Bit counter width is $clog2(WIDTH+1); the CLK_DIV counter width is $clog2(CLK_DIV).
- Reset (asynchronous, any state, including mid-transfer):
  - FSM to IDLE.
  - `sclk`=0, `ss`=0, `mosi`=0, `gnt`=0, `rx_valid`=0, `rx_data`=0, `busy`=0.
  - Arbiter priority returns to requester 0.
  - An aborted transfer produces no `rx_valid`.

## Timing
- Take the grant edge as E. Then:
  - `gnt` and `ss` rise at E.
  - The first `sclk` rise is at E+CLK_DIV.
  - `rx_valid` is high in the cycle after E+CLK_DIV·(2·WIDTH+1), i.e. E+68 for the defaults.
- `sclk` high and low phases are exactly CLK_DIV cycles each.
- `ss` setup before the first rise is CLK_DIV cycles; hold after the last rise is 2·CLK_DIV cycles.
- `ss` is low for at least 2 cycles (DONE + IDLE) between back-to-back transfers.
- `miso` needs no synchronizer: the slave updates it on the `sclk` fall, ≥CLK_DIV cycles before sampling.

## Configuration
- `SPI_RR_ARB_EN` defined:
  - Round-robin arbitration; the requester not granted last wins a tie.
  - After reset, requester 0 wins the first tie.
- Not defined:
  - Fixed priority; requester 0 always wins.
  - Requester 1 is served only when `req[0]`=0 in IDLE.

## Test plan
- Reset applied mid-stream:
  - All outputs 0 immediately, without waiting for a `clk` edge.
  - The first grant after release goes to requester 0.
- `req`=2'b01, `tx_data_0`=8'hA5, slave model returns 8'h3C, CLK_DIV=4:
  - Bits sampled on `mosi` at the `sclk` rises: 1,0,1,0,0,1,0,1.
  - `gnt`=2'b01 for one cycle at E.
  - `rx_valid`=2'b01 at E+68; `rx_data`=8'h3C.
- `req`=2'b11 held for three transfers:
  - With `SPI_RR_ARB_EN`: grant order 0,1,0.
  - Without it: grant order 0,0,0.
- Reset asserted after the 3rd `sclk` rise:
  - `ss` and `sclk` drop asynchronously; no `rx_valid`.
  - The next transfer of 8'hFF completes with the correct `rx_data`.
- CLK_DIV=2, back-to-back transfers:
  - `sclk` high/low exactly 2 cycles each.
  - `ss` low exactly 2 cycles between frames.
- `req[1]` raised for 1 cycle while busy, then dropped: no `gnt[1]` and no `rx_valid[1]`.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// SPI mode-0 master shared by two requesters; one WIDTH-bit full-duplex frame per grant.
// Define SPI_RR_ARB_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

module spi_master_arbiter #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] tx_data_0,
  input  logic [WIDTH-1:0] tx_data_1,
  output logic [1:0]       gnt,
  output logic [1:0]       rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             sclk,
  output logic             ss,
  output logic             mosi,
  input  logic             miso
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_TRAIL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic             owner_q, owner_d;
  logic             sclk_q, sclk_d;
  logic             ss_q, ss_d;
  logic             mosi_q, mosi_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             busy_q, busy_d;
  logic             winner;
  logic             div_last;

`ifdef SPI_RR_ARB_EN
  logic last_q, last_d;

  // A tie goes to whichever requester was not served last.
  always_comb begin
    if (req == 2'b11) begin
      winner = ~last_q;
    end else if (req[0]) begin
      winner = 1'b0;
    end else begin
      winner = 1'b1;
    end
  end
`else
  // Requester 0 always wins.
  always_comb begin
    if (req[0]) begin
      winner = 1'b0;
    end else begin
      winner = 1'b1;
    end
  end
`endif

  assign div_last = (div_q == DIV_LAST);

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    owner_d    = owner_q;
    sclk_d     = sclk_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;
    gnt_d      = 2'b00;
    rx_valid_d = 2'b00;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
`ifdef SPI_RR_ARB_EN
    last_d     = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        ss_d   = 1'b0;
        mosi_d = 1'b0;
        if (req != 2'b00) begin
          owner_d = winner;
          tx_d    = winner ? tx_data_1 : tx_data_0;
          mosi_d  = tx_d[WIDTH-1];
          ss_d    = 1'b1;
          busy_d  = 1'b1;
          gnt_d   = winner ? 2'b10 : 2'b01;
          bit_d   = {BW{1'b0}};
          div_d   = {DW{1'b0}};
          rx_sh_d = {WIDTH{1'b0}};
          state_d = S_LEAD;
`ifdef SPI_RR_ARB_EN
          last_d  = winner;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEAD, S_LOW: begin
        // Rising sclk edge: sample miso alongside the slave sampling mosi.
        if (div_last) begin
          div_d   = {DW{1'b0}};
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[WIDTH-2:0], miso};
          bit_d   = bit_q + 1'b1;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_last) begin
          div_d  = {DW{1'b0}};
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = S_TRAIL;
          end else begin
            tx_d    = {tx_q[WIDTH-2:0], tx_q[WIDTH-1]};
            mosi_d  = tx_d[WIDTH-1];
            state_d = S_LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_TRAIL: begin
        if (div_last) begin
          div_d      = {DW{1'b0}};
          ss_d       = 1'b0;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d    = S_DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        sclk_d  = 1'b0;
        ss_d    = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a completion pulse.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= S_IDLE;
      div_q      <= {DW{1'b0}};
      bit_q      <= {BW{1'b0}};
      tx_q       <= {WIDTH{1'b0}};
      rx_sh_q    <= {WIDTH{1'b0}};
      owner_q    <= 1'b0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b0;
      mosi_q     <= 1'b0;
      gnt_q      <= 2'b00;
      rx_valid_q <= 2'b00;
      rx_data_q  <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
`ifdef SPI_RR_ARB_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      owner_q    <= owner_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      gnt_q      <= gnt_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
`ifdef SPI_RR_ARB_EN
      last_q     <= last_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign ss       = ss_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: cycle-accurate frame model, slave model,
// arbitration model, mid-frame reset and a CLK_DIV=2 instance for phase/gap timing.

module tb_spi_master_arbiter;
  localparam int W      = 8;
  localparam int D      = 4;
  localparam int D2     = 2;
  localparam int T_DONE = D * (2 * W + 1);
  localparam int NS     = 160;

  logic         clk = 1'b0;
  logic         rst_L;
  logic [1:0]   req;
  logic [W-1:0] tx0, tx1;
  logic [1:0]   gnt, rx_valid;
  logic [W-1:0] rx_data;
  logic         busy, sclk, ss, mosi, miso;

  logic [1:0]   req2;
  logic [W-1:0] tx2_0, tx2_1;
  logic [1:0]   gnt2, rxv2;
  logic [W-1:0] rxd2;
  logic         busy2, sclk2, ss2, mosi2, miso2;

  int           checks = 0;
  int           errors = 0;
  int           last_gnt = 1;
  logic [W-1:0] prev_rx = '0;
  logic [W-1:0] sw = '0;
  int           s_idx = W - 1;
  logic         sclk_prev = 1'b0;
  logic         s2c [NS];
  logic         s2s [NS];

  always #5 clk = ~clk;

  spi_master_arbiter #(.WIDTH(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst_L(rst_L), .req(req), .tx_data_0(tx0), .tx_data_1(tx1),
    .gnt(gnt), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_master_arbiter #(.WIDTH(W), .CLK_DIV(D2)) dut2 (
    .clk(clk), .rst_L(rst_L), .req(req2), .tx_data_0(tx2_0), .tx_data_1(tx2_1),
    .gnt(gnt2), .rx_valid(rxv2), .rx_data(rxd2), .busy(busy2),
    .sclk(sclk2), .ss(ss2), .mosi(mosi2), .miso(miso2)
  );

  // Mode-0 slave: presents the MSB while deselected, advances on each sclk fall.
  always @(ss or sclk or sw) begin
    if (ss !== 1'b1) s_idx = W - 1;
    else if (sclk_prev === 1'b1 && sclk === 1'b0) s_idx = s_idx - 1;
    sclk_prev = sclk;
    miso = (s_idx >= 0) ? sw[s_idx] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pin levels i cycles after the grant edge, for divider d.
  function automatic logic e_sclk(int i, int d);
    return (i >= d) && (i < 2 * d * W) && (((i - d) / d) % 2 == 0);
  endfunction

  function automatic logic e_ss(int i, int d);
    return (i < d * (2 * W + 1));
  endfunction

  function automatic logic e_mosi(int i, int d, logic [W-1:0] t);
    if (i >= d * (2 * W + 1)) return 1'b0;
    if (i >= 2 * d * W) return t[0];
    return t[W - 1 - i / (2 * d)];
  endfunction

  function automatic int pick(logic [1:0] r);
`ifdef SPI_RR_ARB_EN
    if (r == 2'b11) return (last_gnt == 0) ? 1 : 0;
`endif
    return r[0] ? 0 : 1;
  endfunction

  task automatic xfer(input logic [1:0] r, input logic [1:0] r_after,
                      input logic [W-1:0] t0, input logic [W-1:0] t1, input logic [W-1:0] s,
                      input int pulse_at, input int abort_at, output int owner_seen);
    int owner;
    logic [W-1:0] t;
    logic got;
    req = r; tx0 = t0; tx1 = t1; sw = s;
    owner = pick(r);
    owner_seen = -1;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      if (gnt !== 2'b00) got = 1'b1;
    end
    chk("gnt_seen", got, 1'b1);
    if (!got) return;
    owner_seen = gnt[1] ? 1 : 0;
    last_gnt = owner;
    t = owner ? t1 : t0;
    chk("gnt", gnt, owner ? 2'b10 : 2'b01);
    chk("ss_at_gnt", ss, 1'b1);
    chk("busy_at_gnt", busy, 1'b1);
    chk("mosi_at_gnt", mosi, t[W-1]);
    req = r_after;
    for (int i = 1; i <= T_DONE + 1; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst_L = 1'b0;
        #1;
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_ss", ss, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rxv", rx_valid, 2'b00);
        chk("rst_rxd", rx_data, '0);
        chk("rst_busy", busy, 1'b0);
        prev_rx = '0;
        last_gnt = 1;
        return;
      end
      chk("sclk", sclk, e_sclk(i, D));
      chk("ss", ss, e_ss(i, D));
      chk("mosi", mosi, e_mosi(i, D, t));
      chk("gnt_idle", gnt, 2'b00);
      chk("busy", busy, (i <= T_DONE));
      chk("rx_valid", rx_valid, (i == T_DONE) ? (owner ? 2'b10 : 2'b01) : 2'b00);
      chk("rx_data", rx_data, (i >= T_DONE) ? s : prev_rx);
      if (i == pulse_at) req = req | 2'b10;
      else if (i == pulse_at + 1) req = r_after;
    end
    prev_rx = s;
  endtask

  initial begin
    int o [3];
    int o1;
    int hi, gaps, start;
    logic cur, all_hi;
    rst_L = 1'b0; req = 2'b00; tx0 = '0; tx1 = '0;
    req2 = 2'b00; tx2_0 = '0; tx2_1 = '0; miso2 = 1'b1;
    #1;
    chk("reset_sclk", sclk, 1'b0);
    chk("reset_ss", ss, 1'b0);
    chk("reset_mosi", mosi, 1'b0);
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_rxv", rx_valid, 2'b00);
    chk("reset_rxd", rx_data, '0);
    chk("reset_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);

    // Tie held for three frames straight out of reset.
    xfer(2'b11, 2'b11, W'($urandom), W'($urandom), W'($urandom), -1, -1, o[0]);
    xfer(2'b11, 2'b11, W'($urandom), W'($urandom), W'($urandom), -1, -1, o[1]);
    xfer(2'b11, 2'b00, W'($urandom), W'($urandom), W'($urandom), -1, -1, o[2]);
    chk("order0", o[0], 0);
`ifdef SPI_RR_ARB_EN
    chk("order1", o[1], 1);
`else
    chk("order1", o[1], 0);
`endif
    chk("order2", o[2], 0);

    // Directed frame: A5 out, 3C back.
    xfer(2'b01, 2'b00, 8'hA5, W'($urandom), 8'h3C, -1, -1, o1);
    chk("a5_owner", o1, 0);

    // req[1] pulsed for one cycle while busy must be ignored.
    xfer(2'b01, 2'b00, W'($urandom), W'($urandom), W'($urandom), 20, -1, o1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_late_gnt", gnt, 2'b00);
      chk("no_late_rxv", rx_valid, 2'b00);
    end

    // Randomized requests and data.
    for (int n = 0; n < 6; n++) begin
      xfer(2'($urandom_range(1, 3)), 2'b00, W'($urandom), W'($urandom), W'($urandom), -1, -1, o1);
    end

    // Reset after the third sclk rise of a requester-1 frame.
    xfer(2'b10, 2'b00, W'($urandom), W'($urandom), W'($urandom), -1, D + 4 * D + 1, o1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_rxv", rx_valid, 2'b00);
      chk("abort_ss", ss, 1'b0);
      chk("abort_sclk", sclk, 1'b0);
    end
    rst_L = 1'b1;
    xfer(2'b11, 2'b00, 8'hFF, W'($urandom), W'($urandom), -1, -1, o1);
    chk("post_reset_owner", o1, 0);

    // CLK_DIV=2 instance, back-to-back frames.
    req2 = 2'b01; tx2_0 = W'($urandom);
    for (int j = 0; j < NS; j++) begin
      @(negedge clk);
      s2c[j] = sclk2;
      s2s[j] = ss2;
      if (rxv2 !== 2'b00) begin
        chk("d2_rxv", rxv2, 2'b01);
        chk("d2_rxd", rxd2, 8'hFF);
      end
    end
    req2 = 2'b00;
    hi = 0; start = 0; cur = s2c[0];
    for (int j = 1; j <= NS; j++) begin
      if (j == NS || s2c[j] !== cur) begin
        if (start > 0 && j < NS) begin
          if (cur) begin
            chk("d2_sclk_high", j - start, D2);
            hi++;
          end else begin
            all_hi = 1'b1;
            for (int m = start; m < j; m++) if (s2s[m] !== 1'b1) all_hi = 1'b0;
            if (all_hi) chk("d2_sclk_low", j - start, D2);
          end
        end
        if (j < NS) begin cur = s2c[j]; start = j; end
      end
    end
    gaps = 0; start = 0; cur = s2s[0];
    for (int j = 1; j <= NS; j++) begin
      if (j == NS || s2s[j] !== cur) begin
        if (start > 0 && j < NS && !cur) begin
          chk("d2_ss_gap", j - start, 2);
          gaps++;
        end
        if (j < NS) begin cur = s2s[j]; start = j; end
      end
    end
    chk("d2_high_runs", (hi >= 2 * W), 1'b1);
    chk("d2_gaps", (gaps >= 2), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
